// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the multiplier job sequencer: sequencer state
// encoding and the default operand width.
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // The fourth 2-bit encoding is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

endpackage

// File: rtl/mult_op_fifo.sv
// -----------------------------------------------------------------------------
// mult_op_fifo
// Small first-word-fall-through FIFO holding packed operand pairs.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset (empties the FIFO)
//   i_push   in   write i_data (caller guarantees !o_full)
//   i_data   in   DATA_W  entry to write
//   i_pop    in   discard head entry (caller guarantees !o_empty)
//   o_data   out  DATA_W  head entry
//   o_full   out  DEPTH entries held
//   o_empty  out  no entries held
// -----------------------------------------------------------------------------
module mult_op_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;

    // NOTE: storage carries no reset; only the pointers and count define
    // which entries are valid, so clearing the array would be wasted logic.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/mult_job_sequencer.sv
// -----------------------------------------------------------------------------
// mult_job_sequencer
// Queues operand pairs from a valid/ready stream, issues them one at a time
// to a shift-add sequential multiplier through its start/valid level
// handshake, and returns each product on a valid/ready output stream.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-high reset (shared with multiplier)
//   in_valid     in   operand pair offered
//   in_ready     out  operand FIFO not full
//   in_a/in_b    in   WIDTH    multiplicand / multiplier
//   mul_start    out  start level to the multiplier controller
//   mul_a/mul_b  out  WIDTH    operands held stable for the job in flight
//   mul_valid    in   multiplier done/idle
//   mul_product  in   2*WIDTH  multiplier product register
//   out_valid    out  result held
//   out_ready    in   consumer accepts
//   out_product  out  2*WIDTH  captured product
//   busy         out  FIFO non-empty or a job in progress
//   timeout_err  out  sticky: multiplier failed to finish within TIMEOUT
//   job_count    out  16       completed jobs (wrapping)
// -----------------------------------------------------------------------------
module mult_job_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 2*WIDTH+8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_valid,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy,
    output logic               timeout_err,
    output logic [15:0]        job_count
);

    localparam int TW = $clog2(TIMEOUT+1);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic               r_out_valid;
    logic [2*WIDTH-1:0] r_out_product;
    logic               r_timeout_err;
    logic [15:0]        r_job_count;
    logic [TW-1:0]      r_tmo;

    logic [2*WIDTH-1:0] w_fifo_data;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_capture;
    logic               w_timeout;

    // Full flag comes straight from the registered count, so a push can
    // never coincide with a full FIFO.
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;

    mult_op_fifo #(
        .DATA_W (2*WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({in_a, in_b}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Only issue once the multiplier reports idle.
                if (!w_empty && mul_valid) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // mul_valid low proves the controller left its final state
                // and has latched the new operands.
                if (!mul_valid) w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_valid && (!r_out_valid || out_ready)) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_tmo == TW'(TIMEOUT-1)) begin
                    // This WAIT cycle is the TIMEOUT-th one: drop the job.
                    w_timeout    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
            r_timeout_err <= 1'b0;
            r_job_count   <= '0;
            r_tmo         <= '0;
        end else begin
            if (w_pop) begin
                r_mul_a <= w_fifo_data[2*WIDTH-1:WIDTH];
                r_mul_b <= w_fifo_data[WIDTH-1:0];
            end

            if (r_state == ST_ISSUE)     r_tmo <= '0;
            else if (r_state == ST_WAIT) r_tmo <= r_tmo + 1'b1;

            if (w_timeout) r_timeout_err <= 1'b1;

            // A capture in the same cycle as a consumer accept keeps
            // out_valid high with the fresh product.
            if (w_capture) begin
                r_out_valid   <= 1'b1;
                r_out_product <= mul_product;
                r_job_count   <= r_job_count + 1'b1;
            end else if (out_ready) begin
                r_out_valid   <= 1'b0;
            end
        end
    end

    assign mul_start   = (r_state == ST_ISSUE);
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign out_valid   = r_out_valid;
    assign out_product = r_out_product;
    assign busy        = !w_empty || (r_state != ST_IDLE);
    assign timeout_err = r_timeout_err;
    assign job_count   = r_job_count;

endmodule
